pid_error_gen: RTL and testbench

Front end for the PI loop: accepts measured-plant samples over a valid/ready stream and averages each group of 2^AVG_LOG2 samples. Subtracts each average from the current setpoint and emits one saturated signed error word per group over a second valid/ready stream. Sits between the ADC/feedback path and the PI controller's `error` input, so the controller only ever sees decimated, clamped error samples.

---
 rtl/pid_error_gen.sv | 122 ++++++++++++
 tb/tb_pid_error_gen.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/pid_error_gen.sv
// Decimating error front end: averages 2^AVG_LOG2 measurements, subtracts the average from the
// setpoint and emits a saturated error word. Optional deadband is enabled with ERR_DEADBAND_EN.
module pid_error_gen #(
    parameter int DATA_W   = 32,
    parameter int AVG_LOG2 = 2,
    parameter int DEADBAND = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] setpoint,
    input  logic [DATA_W-1:0] meas_data,
    input  logic              meas_valid,
    output logic              meas_ready,
    output logic [DATA_W-1:0] err_out,
    output logic              err_valid,
    input  logic              err_ready,
    output logic              err_sat
);

    localparam int ACC_W = DATA_W + AVG_LOG2;
    localparam int CNT_W = AVG_LOG2 + 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'((1 << AVG_LOG2) - 1);

    typedef enum logic [1:0] {
        ACCUM,
        COMPUTE,
        HOLD
    } state_t;

    state_t            state_q, state_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] err_q, err_d;
    logic              sat_q, sat_d;
    logic              valid_q, valid_d;

    logic signed [ACC_W-1:0]   avg_w;
    logic signed [ACC_W:0]     diff_w;
    logic [ACC_W:DATA_W-1]     diff_top;
    logic                      ovf;
    logic [DATA_W-1:0]         sat_val;
    logic [DATA_W-1:0]         err_val;

    if (DEADBAND < 0) begin : g_bad_deadband
        $error("DEADBAND must be non-negative");
    end

    // The difference is formed at full accumulator width; the average always fits DATA_W,
    // so overflow shows up as the bits above DATA_W-1 not being a pure sign extension.
    assign avg_w    = $signed(acc_q) >>> AVG_LOG2;
    assign diff_w   = (ACC_W + 1)'($signed(setpoint)) - (ACC_W + 1)'(avg_w);
    assign diff_top = diff_w[ACC_W:DATA_W-1];
    assign ovf      = !((&diff_top) || !(|diff_top));
    assign sat_val  = !ovf ? diff_w[DATA_W-1:0]
                    : diff_w[ACC_W] ? {1'b1, {(DATA_W-1){1'b0}}}
                    : {1'b0, {(DATA_W-1){1'b1}}};

`ifdef ERR_DEADBAND_EN
    logic [ACC_W:0] diff_mag;
    assign diff_mag = diff_w[ACC_W] ? (ACC_W + 1)'(-diff_w) : (ACC_W + 1)'(diff_w);
    assign err_val  = (diff_mag <= (ACC_W + 1)'(DEADBAND)) ? '0 : sat_val;
`else
    assign err_val  = sat_val;
`endif

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        sat_d   = sat_q;
        valid_d = valid_q;
        case (state_q)
            ACCUM: begin
                if (meas_valid) begin
                    acc_d = acc_q + ACC_W'($signed(meas_data));
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST) state_d = COMPUTE;
                end
            end
            COMPUTE: begin
                err_d   = err_val;
                sat_d   = ovf;
                valid_d = 1'b1;
                state_d = HOLD;
            end
            HOLD: begin
                if (err_ready) begin
                    valid_d = 1'b0;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = ACCUM;
                end
            end
            default: state_d = ACCUM;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ACCUM;
            acc_q   <= '0;
            cnt_q   <= '0;
            err_q   <= '0;
            sat_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            sat_q   <= sat_d;
            valid_q <= valid_d;
        end
    end

    assign meas_ready = (state_q == ACCUM);
    assign err_out    = err_q;
    assign err_sat    = sat_q;
    assign err_valid  = valid_q;

endmodule

// File: tb/tb_pid_error_gen.sv
// Scoreboard bench for pid_error_gen: stimulus pushes expected words, a monitor pops on handshake.
module tb_pid_error_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] setpoint;
    logic [31:0] meas_data;
    logic        meas_valid;
    logic        meas_ready;
    logic [31:0] err_out;
    logic        err_valid;
    logic        err_ready;
    logic        err_sat;

    typedef struct packed {
        logic [31:0] err;
        logic        sat;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    pid_error_gen #(.DATA_W(32), .AVG_LOG2(2), .DEADBAND(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .setpoint   (setpoint),
        .meas_data  (meas_data),
        .meas_valid (meas_valid),
        .meas_ready (meas_ready),
        .err_out    (err_out),
        .err_valid  (err_valid),
        .err_ready  (err_ready),
        .err_sat    (err_sat)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s: timed out waiting on DUT", name);
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst && err_valid && err_ready) begin
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_word: got %h expected none", err_out);
            end else begin
                e = q.pop_front();
                check("err_out", err_out, e.err);
                check("err_sat", {31'b0, err_sat}, {31'b0, e.sat});
            end
        end
    end

    task automatic push(input logic [31:0] err, input logic sat);
        exp_t e;
        e.err = err;
        e.sat = sat;
        q.push_back(e);
    endtask

    // Called just after a rising edge; returns just after the edge that accepted the sample.
    task automatic send(input logic [31:0] d);
        int n = 0;
        meas_data  = d;
        meas_valid = 1'b1;
        @(negedge clk);
        while (!meas_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!meas_ready) fail_now("send");
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n = 0;
        err_ready = 1'b1;
        while (q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0) begin
            fail_now("drain");
        end else begin
            @(posedge clk);
            #1;
            check("ready_after_hs", {31'b0, meas_ready}, 32'd1);
            check("valid_clear_after_hs", {31'b0, err_valid}, 32'd0);
        end
    endtask

    task automatic group(input logic [31:0] sp, input logic [31:0] s,
                         input logic [31:0] exp, input logic sat);
        setpoint = sp;
        push(exp, sat);
        repeat (4) send(s);
        meas_valid = 1'b0;
        drain();
    endtask

    initial begin
        rst        = 1'b1;
        setpoint   = '0;
        meas_data  = '0;
        meas_valid = 1'b0;
        err_ready  = 1'b0;
        #12;
        check("rst_err_out", err_out, 32'd0);
        check("rst_err_valid", {31'b0, err_valid}, 32'd0);
        check("rst_err_sat", {31'b0, err_sat}, 32'd0);
        check("rst_meas_ready", {31'b0, meas_ready}, 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Average with latency check
        err_ready = 1'b0;
        setpoint  = 32'd1000;
        push(32'd900, 1'b0);
        send(32'd100);
        send(32'd102);
        send(32'd98);
        send(32'd100);
        meas_valid = 1'b0;
        check("compute_valid_low", {31'b0, err_valid}, 32'd0);
        check("compute_ready_low", {31'b0, meas_ready}, 32'd0);
        @(posedge clk);
        #1;
        check("valid_after_compute", {31'b0, err_valid}, 32'd1);
        drain();

        // Floor rounding
        setpoint = 32'd0;
        push(32'd3, 1'b0);
        send(-32'sd3);
        send(-32'sd3);
        send(-32'sd3);
        send(-32'sd2);
        meas_valid = 1'b0;
        drain();

        // Saturation both directions
        group(32'h7FFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 1'b1);
        group(32'h8000_0000, 32'h7FFF_FFFF, 32'h8000_0000, 1'b1);

        // Backpressure with a held sample and a setpoint change in HOLD
        err_ready = 1'b0;
        setpoint  = 32'd50;
        push(32'd40, 1'b0);
        repeat (4) send(32'd10);
        meas_data  = 32'd7;
        meas_valid = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_err_valid", {31'b0, err_valid}, 32'd1);
            check("bp_err_out", err_out, 32'd40);
            check("bp_err_sat", {31'b0, err_sat}, 32'd0);
            check("bp_meas_ready", {31'b0, meas_ready}, 32'd0);
        end
        @(posedge clk);
        #1;
        setpoint = 32'd10;
        drain();
        push(32'd3, 1'b0);
        repeat (4) send(32'd7);
        meas_valid = 1'b0;
        drain();

        // Reset mid-group, then reset with a word pending in HOLD
        err_ready = 1'b0;
        send(32'd500);
        send(32'd500);
        meas_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("midgrp_rst_ready", {31'b0, meas_ready}, 32'd1);
        check("midgrp_rst_valid", {31'b0, err_valid}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        setpoint = 32'd0;
        repeat (4) send(32'd1);
        meas_valid = 1'b0;
        @(posedge clk);
        #1;
        check("pending_valid", {31'b0, err_valid}, 32'd1);
        check("pending_out", err_out, 32'hFFFF_FFFF);
        #2 rst = 1'b1;
        #1;
        check("hold_rst_valid", {31'b0, err_valid}, 32'd0);
        check("hold_rst_out", err_out, 32'd0);
        check("hold_rst_ready", {31'b0, meas_ready}, 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        group(32'd20, 32'd10, 32'd10, 1'b0);

        // Deadband
`ifdef ERR_DEADBAND_EN
        group(32'd110, 32'd100, 32'd0, 1'b0);
        group(32'd84, 32'd100, 32'd0, 1'b0);
        group(32'd116, 32'd100, 32'd0, 1'b0);
`else
        group(32'd110, 32'd100, 32'd10, 1'b0);
        group(32'd84, 32'd100, -32'sd16, 1'b0);
        group(32'd116, 32'd100, 32'd16, 1'b0);
`endif
        group(32'd117, 32'd100, 32'd17, 1'b0);
        group(32'd83, 32'd100, -32'sd17, 1'b0);

        repeat (5) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
